// File: rtl/fifo_pkg.sv
// Shared sizing constants and the write-arbiter state encoding for the FIFO
// producer-side blocks.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int RETRY_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2,
    HOLD  = 2'd3
  } wr_state_e;

endpackage : fifo_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the request at index ptr has highest
// priority, then ptr+1 and onward, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit is the winner.
  // NOTE: every output and temporary gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ producers onto one FIFO write port: latch a round-robin
// winner, write it, and grant only once the FIFO acknowledges the word.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int NUM_REQ    = fifo_pkg::NUM_REQ
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic                                 wr_en,
  output logic [FIFO_WIDTH-1:0]                data_in,
  input  logic                                 full,
  input  logic                                 wr_ack,
  input  logic                                 overflow,
  output logic [7:0]                           retry_cnt,
  output logic                                 busy
);

  import fifo_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_state_e                state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         winner_idx_q;
  logic [NUM_REQ-1:0]       winner_oh_q;
  logic [FIFO_WIDTH-1:0]    word_q;
  logic [7:0]               retry_q;
  logic                     latch_en;
  logic                     retry_inc;
  logic [NUM_REQ-1:0]       rr_gnt;
  logic [IDX_W-1:0]         rr_idx;
  logic [IDX_W-1:0]         ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign ptr_next = (winner_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    latch_en  = 1'b0;
    retry_inc = 1'b0;
    wr_en     = 1'b0;
    gnt       = '0;
    unique case (state_q)
      IDLE: begin
        if (|req && !full) begin
          latch_en = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if (wr_ack) begin
          gnt     = winner_oh_q;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else begin
          retry_inc = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!full) state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The latched word and winner are cleared too, so an interrupted write
  // leaves nothing behind after reset.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_idx_q <= '0;
      winner_oh_q  <= '0;
      word_q       <= '0;
      retry_q      <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (latch_en) begin
        winner_idx_q <= rr_idx;
        winner_oh_q  <= rr_gnt;
        word_q       <= req_data[rr_idx];
      end
      if (retry_inc && retry_q != 8'(RETRY_MAX)) begin
        retry_q <= retry_q + 8'd1;
      end
    end
  end

  assign data_in   = word_q;
  assign retry_cnt = retry_q;
  assign busy      = (state_q != IDLE);

  // The FIFO's overflow flag must be the exact complement of wr_ack whenever
  // the acknowledge is being consumed.
  a_overflow_consistent : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ACK) |-> (overflow == !wr_ack)
  );

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small behavioural FIFO that
// registers wr_ack/overflow and can be told to reject a number of writes.
module tb_fifo_wr_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][15:0] req_data;
  logic [3:0]       gnt;
  logic             wr_en;
  logic [15:0]      data_in;
  logic             full;
  logic             wr_ack = 1'b0;
  logic             overflow = 1'b0;
  logic [7:0]       retry_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_q[$];
  int          fail_budget = 0;
  int          fail_used = 0;

  fifo_wr_arbiter #(
    .FIFO_WIDTH (16),
    .NUM_REQ    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .full      (full),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .retry_cnt (retry_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: a write is rejected while a forced failure is pending or the
  // FIFO is full; the response appears the cycle after wr_en.
  always @(posedge clk) begin
    if (wr_en) begin
      if (fail_used < fail_budget || full) begin
        wr_ack   <= 1'b0;
        overflow <= 1'b1;
        if (fail_used < fail_budget) fail_used <= fail_used + 1;
      end else begin
        fifo_q.push_back(data_in);
        wr_ack   <= 1'b1;
        overflow <= 1'b0;
      end
    end else begin
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n       = 1'b0;
    req         = '0;
    req_data    = '0;
    full        = 1'b0;
    fail_budget = fail_used;
    tick();
    tick();
    fifo_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int max_cycles, output logic [3:0] g, output int cycles);
    g      = '0;
    cycles = 0;
    while (cycles < max_cycles) begin
      tick();
      cycles++;
      if (gnt !== 4'b0000) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, wr_en, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got gnt=%b wr_en=%b busy=%b exp all 0", gnt, wr_en, busy);
    end
    checks++;
    if (data_in !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data_in got %h exp 0000", data_in);
    end
    checks++;
    if (retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_retry_cnt got %0d exp 0", retry_cnt);
    end
    reset_dut();
    tick();
    checks++;
    if ({gnt, wr_en, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle got gnt=%b wr_en=%b busy=%b exp all 0", gnt, wr_en, busy);
    end
  endtask

  task automatic test_single();
    reset_dut();
    req         = 4'b0001;
    req_data[0] = 16'hA5A5;
    tick();
    checks++;
    if (wr_en !== 1'b1 || data_in !== 16'hA5A5 || gnt !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_write got wr_en=%b data=%h gnt=%b busy=%b exp 1 a5a5 0000 1",
               wr_en, data_in, gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt got gnt=%b wr_en=%b exp 0001 0", gnt, wr_en);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || data_in !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_idle got busy=%b gnt=%b data=%h exp 0 0000 a5a5", busy, gnt, data_in);
    end
    checks++;
    if (fifo_q.size() != 1 || fifo_q[0] !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_fifo got size=%0d exp 1 word a5a5", fifo_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int         cyc;
    logic [15:0] exp_w;
    reset_dut();
    for (int i = 0; i < 4; i++) req_data[i] = 16'(16'h1000 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(10, g, cyc);
      checks++;
      if (g !== 4'(1 << (k % 4)) || cyc != ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL rr_grant_%0d got gnt=%b after %0d cycles exp %b after %0d",
                 k, g, cyc, 4'(1 << (k % 4)), (k == 0) ? 2 : 3);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (fifo_q.size() != 5) begin
      errors++;
      $display("FAIL rr_fifo_size got %0d exp 5", fifo_q.size());
    end
    for (int k = 0; k < 5 && k < fifo_q.size(); k++) begin
      exp_w = 16'(16'h1000 + (k % 4));
      checks++;
      if (fifo_q[k] !== exp_w) begin
        errors++;
        $display("FAIL rr_fifo_word_%0d got %h exp %h", k, fifo_q[k], exp_w);
      end
    end
  endtask

  task automatic test_full();
    logic [3:0] g;
    int         cyc;
    reset_dut();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'(i));
    full        = 1'b1;
    req         = 4'b0010;
    req_data[1] = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL full_stall_%0d got wr_en=%b busy=%b exp 0 0", k, wr_en, busy);
      end
    end
    void'(fifo_q.pop_front());
    full = 1'b0;
    wait_gnt(10, g, cyc);
    checks++;
    if (g !== 4'b0010 || cyc != 2) begin
      errors++;
      $display("FAIL full_resume got gnt=%b after %0d cycles exp 0010 after 2", g, cyc);
    end
    req = 4'b0000;
    checks++;
    if (fifo_q.size() != 8 || fifo_q[fifo_q.size()-1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL full_fifo got size=%0d exp 8 ending beef", fifo_q.size());
    end
  endtask

  task automatic test_overflow_retry();
    logic [3:0] g;
    int         cyc;
    reset_dut();
    fail_budget = fail_used + 1;
    req         = 4'b0100;
    req_data[2] = 16'h5A5A;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_no_gnt got %b exp 0000", gnt);
    end
    tick();
    checks++;
    if (retry_cnt !== 8'd1 || busy !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_hold got retry=%0d busy=%b wr_en=%b exp 1 1 0", retry_cnt, busy, wr_en);
    end
    tick();
    checks++;
    if (wr_en !== 1'b1 || data_in !== 16'h5A5A) begin
      errors++;
      $display("FAIL ovf_rewrite got wr_en=%b data=%h exp 1 5a5a", wr_en, data_in);
    end
    wait_gnt(5, g, cyc);
    checks++;
    if (g !== 4'b0100 || cyc != 1) begin
      errors++;
      $display("FAIL ovf_gnt got gnt=%b after %0d cycles exp 0100 after 1", g, cyc);
    end
    req = 4'b0000;
    checks++;
    if (fifo_q.size() != 1 || fifo_q[0] !== 16'h5A5A) begin
      errors++;
      $display("FAIL ovf_fifo got size=%0d exp 1 word 5a5a", fifo_q.size());
    end
  endtask

  task automatic test_req_drop();
    logic [3:0] g;
    int         cyc;
    reset_dut();
    req         = 4'b0100;
    req_data[2] = 16'h7777;
    tick();
    req      = 4'b0000;
    req_data = '0;
    wait_gnt(5, g, cyc);
    checks++;
    if (g !== 4'b0100 || cyc != 1) begin
      errors++;
      $display("FAIL drop_gnt got gnt=%b after %0d cycles exp 0100 after 1", g, cyc);
    end
    checks++;
    if (fifo_q.size() != 1 || fifo_q[0] !== 16'h7777) begin
      errors++;
      $display("FAIL drop_fifo got size=%0d exp 1 word 7777", fifo_q.size());
    end
  endtask

  task automatic test_reset_in_ack();
    logic [3:0] g;
    int         cyc;
    reset_dut();
    req         = 4'b0010;
    req_data[1] = 16'h1111;
    wait_gnt(5, g, cyc);
    req = 4'b0000;
    tick();
    req         = 4'b1000;
    req_data[3] = 16'h2222;
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0 ||
        data_in !== 16'h0000 || retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_ack_outputs got gnt=%b wr_en=%b busy=%b data=%h retry=%0d exp all 0",
               gnt, wr_en, busy, data_in, retry_cnt);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 16'(16'h1000 + i);
    req = 4'b1111;
    wait_gnt(5, g, cyc);
    checks++;
    if (g !== 4'b0001 || cyc != 2) begin
      errors++;
      $display("FAIL rst_ack_ptr got gnt=%b after %0d cycles exp 0001 after 2", g, cyc);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_saturate();
    logic [3:0] g;
    int         cyc;
    int         base;
    reset_dut();
    base        = fail_used;
    fail_budget = fail_used + 260;
    req         = 4'b0001;
    req_data[0] = 16'hC0DE;
    wait_gnt(1000, g, cyc);
    req = 4'b0000;
    checks++;
    if (g !== 4'b0001 || cyc != 782) begin
      errors++;
      $display("FAIL sat_gnt got gnt=%b after %0d cycles exp 0001 after 782", g, cyc);
    end
    checks++;
    if (retry_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_retry_cnt got %0d exp 255", retry_cnt);
    end
    checks++;
    if (fail_used - base != 260) begin
      errors++;
      $display("FAIL sat_attempts got %0d rejected writes exp 260", fail_used - base);
    end
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    full     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_overflow_retry();
    test_req_drop();
    test_reset_in_ack();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
